// File: rtl/ulab_sel_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath: IR fields and flags in,
// mux selects, ALU op and write enables out. Clock and reset are carried outside as plain ports.
interface ulab_sel_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] ula_b_sel;
   logic       ula_a_sel;
   logic [2:0] ula_op;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       mem_wr;
   logic       iord;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       invalid_op;
   logic [4:0] state_dbg;

   modport master (
      input  opcode, funct, zero,
      output ula_b_sel, ula_a_sel, ula_op, pc_write, pc_write_cond, pc_src,
             ir_write, mem_wr, iord, reg_write, reg_dst, mem_to_reg, invalid_op, state_dbg
   );

   modport slave (
      output opcode, funct, zero,
      input  ula_b_sel, ula_a_sel, ula_op, pc_write, pc_write_cond, pc_src,
             ir_write, mem_wr, iord, reg_write, reg_dst, mem_to_reg, invalid_op, state_dbg
   );
endinterface

// File: rtl/ulab_sel_ctrl.sv
// Multicycle control sequencer (add/sub/and, addi, lui, lw, sw, beq, j) with registered Moore outputs.
// Latency: fetch and memory states last MEM_WAIT cycles, others one; no backpressure, memory waits are a fixed count.
module ulab_sel_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input  logic            clk,
   input  logic            reset,
   ulab_sel_ctrl_if.master bus
);
   localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

   typedef enum logic [4:0] {
      FETCH    = 5'd0,  DECODE = 5'd1,  EXEC_R   = 5'd2,  WB_R   = 5'd3,
      EXEC_I   = 5'd4,  WB_I   = 5'd5,  EXEC_LUI = 5'd6,  ADDR   = 5'd7,
      MEM_RD   = 5'd8,  WB_LW  = 5'd9,  MEM_WR   = 5'd10, BRANCH = 5'd11,
      JUMP     = 5'd12, HALT   = 5'd13
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       invalid_q, invalid_d;
   logic [2:0] b_sel_q, b_sel_d, op_q, op_d;
   logic [1:0] pc_src_q, pc_src_d;
   logic       a_sel_q, a_sel_d, pcw_q, pcw_d, pcwc_q, pcwc_d, irw_q, irw_d;
   logic       mwr_q, mwr_d, iord_q, iord_d, rw_q, rw_d, rdst_q, rdst_d, m2r_q, m2r_d;
   logic       r_ok;
   logic       unused_zero;

   // The zero flag gates the PC load in the datapath, not here.
   assign unused_zero = bus.zero;
   assign r_ok = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) || (bus.funct == 6'b100100);

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      case (state_q)
         FETCH:    if (cnt_q == LAST) state_d = DECODE; else cnt_d = cnt_q + 3'd1;
         DECODE: begin
            case (bus.opcode)
               6'b000000: state_d = r_ok ? EXEC_R : HALT;
               6'b001000: state_d = EXEC_I;
               6'b001111: state_d = EXEC_LUI;
               6'b100011,
               6'b101011: state_d = ADDR;
               6'b000100: state_d = BRANCH;
               6'b000010: state_d = JUMP;
               default:   state_d = HALT;
            endcase
         end
         EXEC_R:   state_d = WB_R;
         EXEC_I:   state_d = WB_I;
         EXEC_LUI: state_d = WB_I;
         ADDR:     state_d = (bus.opcode == 6'b100011) ? MEM_RD : MEM_WR;
         MEM_RD:   if (cnt_q == LAST) state_d = WB_LW; else cnt_d = cnt_q + 3'd1;
         MEM_WR:   if (cnt_q == LAST) state_d = FETCH; else cnt_d = cnt_q + 3'd1;
         HALT:     state_d = HALT;
         default:  state_d = FETCH;
      endcase
      invalid_d = invalid_q | (state_d == HALT);
   end

   // Outputs are decoded from the state being entered so the registers line up with state_q.
   always_comb begin
      b_sel_d  = 3'b000;
      a_sel_d  = 1'b0;
      op_d     = 3'b001;
      pc_src_d = 2'b00;
      pcw_d    = 1'b0;
      pcwc_d   = 1'b0;
      irw_d    = 1'b0;
      mwr_d    = 1'b0;
      iord_d   = 1'b0;
      rw_d     = 1'b0;
      rdst_d   = 1'b0;
      m2r_d    = 1'b0;
      case (state_d)
         FETCH: begin
            irw_d = (cnt_d == LAST);
            pcw_d = (cnt_d == LAST);
         end
         DECODE:   b_sel_d = 3'b100;
         EXEC_R: begin
            a_sel_d = 1'b1;
            b_sel_d = 3'b001;
            if (bus.funct == 6'b100010)      op_d = 3'b010;
            else if (bus.funct == 6'b100100) op_d = 3'b011;
         end
         WB_R: begin
            rw_d   = 1'b1;
            rdst_d = 1'b1;
         end
         EXEC_I, ADDR: begin
            a_sel_d = 1'b1;
            b_sel_d = 3'b010;
         end
         WB_I:     rw_d = 1'b1;
         EXEC_LUI: begin
            b_sel_d = 3'b101;
            op_d    = 3'b000;
         end
         MEM_RD:   iord_d = 1'b1;
         WB_LW: begin
            rw_d  = 1'b1;
            m2r_d = 1'b1;
         end
         MEM_WR: begin
            iord_d = 1'b1;
            mwr_d  = 1'b1;
         end
         BRANCH: begin
            a_sel_d  = 1'b1;
            b_sel_d  = 3'b001;
            op_d     = 3'b010;
            pcwc_d   = 1'b1;
            pc_src_d = 2'b01;
         end
         JUMP: begin
            pcw_d    = 1'b1;
            pc_src_d = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         invalid_q <= 1'b0;
         b_sel_q   <= 3'b000;
         a_sel_q   <= 1'b0;
         op_q      <= 3'b001;
         pc_src_q  <= 2'b00;
         pcw_q     <= 1'b0;
         pcwc_q    <= 1'b0;
         irw_q     <= 1'b0;
         mwr_q     <= 1'b0;
         iord_q    <= 1'b0;
         rw_q      <= 1'b0;
         rdst_q    <= 1'b0;
         m2r_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         invalid_q <= invalid_d;
         b_sel_q   <= b_sel_d;
         a_sel_q   <= a_sel_d;
         op_q      <= op_d;
         pc_src_q  <= pc_src_d;
         pcw_q     <= pcw_d;
         pcwc_q    <= pcwc_d;
         irw_q     <= irw_d;
         mwr_q     <= mwr_d;
         iord_q    <= iord_d;
         rw_q      <= rw_d;
         rdst_q    <= rdst_d;
         m2r_q     <= m2r_d;
      end
   end

   assign bus.ula_b_sel     = b_sel_q;
   assign bus.ula_a_sel     = a_sel_q;
   assign bus.ula_op        = op_q;
   assign bus.pc_src        = pc_src_q;
   assign bus.pc_write      = pcw_q;
   assign bus.pc_write_cond = pcwc_q;
   assign bus.ir_write      = irw_q;
   assign bus.mem_wr        = mwr_q;
   assign bus.iord          = iord_q;
   assign bus.reg_write     = rw_q;
   assign bus.reg_dst       = rdst_q;
   assign bus.mem_to_reg    = m2r_q;
   assign bus.invalid_op    = invalid_q;
   assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_ulab_sel_ctrl.sv
// Self-checking bench for ulab_sel_ctrl: per-instruction expected cycle streams are queued, then popped each cycle.
module tb_ulab_sel_ctrl;
   localparam int MW = 3;
   localparam logic [4:0] S_FETCH = 5'd0, S_DECODE = 5'd1, S_EXEC_R = 5'd2, S_WB_R = 5'd3,
                          S_EXEC_I = 5'd4, S_WB_I = 5'd5, S_EXEC_LUI = 5'd6, S_ADDR = 5'd7,
                          S_MEM_RD = 5'd8, S_WB_LW = 5'd9, S_MEM_WR = 5'd10, S_BRANCH = 5'd11,
                          S_JUMP = 5'd12, S_HALT = 5'd13;
   // enable bits: {pc_write, pc_write_cond, ir_write, mem_wr, iord, reg_write, reg_dst, mem_to_reg, invalid_op}
   localparam logic [8:0] E_PCW = 9'h100, E_PCWC = 9'h080, E_IRW = 9'h040, E_MWR = 9'h020,
                          E_IORD = 9'h010, E_RW = 9'h008, E_RDST = 9'h004, E_M2R = 9'h002,
                          E_INV = 9'h001, E_NONE = 9'h000;
   // care bits: {b_sel, a_sel, ula_op, pc_src, reg_dst/mem_to_reg}
   localparam logic [4:0] C_B = 5'h10, C_A = 5'h08, C_OP = 5'h04, C_SRC = 5'h02, C_SEL = 5'h01,
                          C_ALU = 5'h1C, C_ALL = 5'h1F, C_NONE = 5'h00;

   typedef struct packed {
      logic [4:0] st;
      logic [2:0] b;
      logic       a;
      logic [2:0] op;
      logic [1:0] src;
      logic [8:0] en;
   } obs_t;

   typedef struct {
      string nm;
      obs_t  v;
      obs_t  m;
   } exp_t;

   typedef struct {
      string      nm;
      logic [5:0] opc;
      logic [5:0] fn;
      logic       z;
      logic [2:0] ex_b;
      logic       ex_a;
      logic [2:0] ex_op;
      logic [4:0] ex_care;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];
   vec_t vecs[10];

   always #5 clk = ~clk;

   ulab_sel_ctrl_if bus();
   ulab_sel_ctrl #(.MEM_WAIT(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

   function automatic obs_t sample();
      obs_t o;
      o.st  = bus.state_dbg;
      o.b   = bus.ula_b_sel;
      o.a   = bus.ula_a_sel;
      o.op  = bus.ula_op;
      o.src = bus.pc_src;
      o.en  = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_wr, bus.iord,
               bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.invalid_op};
      return o;
   endfunction

   task automatic cmp(input exp_t e);
      logic [22:0] av, ev, mv;
      av = sample();
      ev = e.v;
      mv = e.m;
      n_chk++;
      if (((av ^ ev) & mv) != '0) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h required %h (mask %h)", e.nm, $time, av, ev, mv);
      end
   endtask

   task automatic push(input string nm, input logic [4:0] st, input logic [2:0] b, input logic a,
                       input logic [2:0] op, input logic [1:0] src, input logic [8:0] en,
                       input logic [4:0] care);
      exp_t e;
      e.nm = nm;
      e.v  = {st, b, a, op, src, en};
      e.m  = {5'h1F, {3{care[4]}}, care[3], {3{care[2]}}, {2{care[1]}}, 6'h3F, {2{care[0]}}, 1'b1};
      q.push_back(e);
   endtask

   task automatic push_fetch_decode();
      for (int i = 0; i < MW; i++) begin
         if (i == MW - 1) push("fetch_last", S_FETCH, 3'b000, 1'b0, 3'b001, 2'b00, E_PCW | E_IRW, C_ALU | C_SRC);
         else             push("fetch", S_FETCH, 3'b000, 1'b0, 3'b001, 2'b00, E_NONE, C_ALU);
      end
      push("decode", S_DECODE, 3'b100, 1'b0, 3'b001, 2'b00, E_NONE, C_ALU);
   endtask

   task automatic gen_instr(input vec_t v);
      push_fetch_decode();
      case (v.opc)
         6'h00: begin
            push({v.nm, "_exec"}, S_EXEC_R, v.ex_b, v.ex_a, v.ex_op, 2'b00, E_NONE, v.ex_care);
            push({v.nm, "_wb"}, S_WB_R, 3'b000, 1'b0, 3'b000, 2'b00, E_RW | E_RDST, C_SEL);
         end
         6'h08, 6'h0F: begin
            push({v.nm, "_exec"}, (v.opc == 6'h08) ? S_EXEC_I : S_EXEC_LUI,
                 v.ex_b, v.ex_a, v.ex_op, 2'b00, E_NONE, v.ex_care);
            push({v.nm, "_wb"}, S_WB_I, 3'b000, 1'b0, 3'b000, 2'b00, E_RW, C_SEL);
         end
         6'h23: begin
            push({v.nm, "_addr"}, S_ADDR, v.ex_b, v.ex_a, v.ex_op, 2'b00, E_NONE, v.ex_care);
            for (int i = 0; i < MW; i++) push({v.nm, "_memrd"}, S_MEM_RD, 3'b000, 1'b0, 3'b000, 2'b00, E_IORD, C_NONE);
            push({v.nm, "_wb"}, S_WB_LW, 3'b000, 1'b0, 3'b000, 2'b00, E_RW | E_M2R, C_SEL);
         end
         6'h2B: begin
            push({v.nm, "_addr"}, S_ADDR, v.ex_b, v.ex_a, v.ex_op, 2'b00, E_NONE, v.ex_care);
            for (int i = 0; i < MW; i++) push({v.nm, "_memwr"}, S_MEM_WR, 3'b000, 1'b0, 3'b000, 2'b00, E_IORD | E_MWR, C_NONE);
         end
         6'h04: push({v.nm, "_branch"}, S_BRANCH, v.ex_b, v.ex_a, v.ex_op, 2'b01, E_PCWC, v.ex_care | C_SRC);
         6'h02: push({v.nm, "_jump"}, S_JUMP, v.ex_b, v.ex_a, v.ex_op, 2'b10, E_PCW, v.ex_care | C_SRC);
         default: push({v.nm, "_halt"}, S_HALT, 3'b000, 1'b0, 3'b000, 2'b00, E_INV, C_SEL);
      endcase
   endtask

   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         cmp(e);
         @(negedge clk);
      end
   endtask

   task automatic run(input vec_t v);
      bus.opcode = v.opc;
      bus.funct  = v.fn;
      bus.zero   = v.z;
      gen_instr(v);
      drain();
   endtask

   task automatic check_reset(input string nm);
      exp_t e;
      q.delete();
      push(nm, S_FETCH, 3'b000, 1'b0, 3'b001, 2'b00, E_NONE, C_ALL);
      e = q.pop_front();
      cmp(e);
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b0;
      #1;
      check_reset(nm);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // The ALU-B selector must only ever carry legal codes, in every state and during reset.
   always @(negedge clk) begin
      n_chk++;
      if (bus.ula_b_sel inside {3'b011, 3'b110, 3'b111}) begin
         n_fail++;
         $display("FAIL b_sel_legal @%0t: got %b, required a legal code", $time, bus.ula_b_sel);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{"add",   6'h00, 6'h20, 1'b0, 3'b001, 1'b1, 3'b001, C_ALU};
      vecs[1] = '{"sub",   6'h00, 6'h22, 1'b0, 3'b001, 1'b1, 3'b010, C_ALU};
      vecs[2] = '{"and",   6'h00, 6'h24, 1'b0, 3'b001, 1'b1, 3'b011, C_ALU};
      vecs[3] = '{"addi",  6'h08, 6'h3F, 1'b0, 3'b010, 1'b1, 3'b001, C_ALU};
      vecs[4] = '{"lui",   6'h0F, 6'h00, 1'b0, 3'b101, 1'b0, 3'b000, C_B | C_OP};
      vecs[5] = '{"lw",    6'h23, 6'h00, 1'b0, 3'b010, 1'b1, 3'b001, C_ALU};
      vecs[6] = '{"sw",    6'h2B, 6'h00, 1'b0, 3'b010, 1'b1, 3'b001, C_ALU};
      vecs[7] = '{"beq_z1",6'h04, 6'h00, 1'b1, 3'b001, 1'b1, 3'b010, C_ALU};
      vecs[8] = '{"beq_z0",6'h04, 6'h00, 1'b0, 3'b001, 1'b1, 3'b010, C_ALU};
      vecs[9] = '{"j",     6'h02, 6'h00, 1'b0, 3'b000, 1'b0, 3'b000, C_NONE};

      bus.opcode = 6'h00;
      bus.funct  = 6'h00;
      bus.zero   = 1'b0;
      repeat (2) @(negedge clk);
      do_reset("reset_init");

      foreach (vecs[i]) run(vecs[i]);

      // Illegal opcode: halts with a sticky flag until reset.
      bus.opcode = 6'h3F;
      push_fetch_decode();
      for (int i = 0; i < 20; i++) push("halt_3f", S_HALT, 3'b000, 1'b0, 3'b000, 2'b00, E_INV, C_SEL);
      drain();
      do_reset("reset_after_halt");

      // R-type with an unsupported funct also halts.
      bus.opcode = 6'h00;
      bus.funct  = 6'h25;
      push_fetch_decode();
      for (int i = 0; i < 3; i++) push("halt_rfunct", S_HALT, 3'b000, 1'b0, 3'b000, 2'b00, E_INV, C_SEL);
      drain();
      do_reset("reset_after_halt_r");

      // Reset pulled mid-store: mem_wr must drop asynchronously.
      bus.opcode = 6'h2B;
      bus.funct  = 6'h00;
      push_fetch_decode();
      push("sw_addr", S_ADDR, 3'b010, 1'b1, 3'b001, 2'b00, E_NONE, C_ALU);
      push("sw_memwr0", S_MEM_WR, 3'b000, 1'b0, 3'b000, 2'b00, E_IORD | E_MWR, C_NONE);
      push("sw_memwr1", S_MEM_WR, 3'b000, 1'b0, 3'b000, 2'b00, E_IORD | E_MWR, C_NONE);
      while (q.size() > 1) begin
         exp_t e;
         e = q.pop_front();
         cmp(e);
         @(negedge clk);
      end
      begin
         exp_t e;
         e = q.pop_front();
         cmp(e);
      end
      do_reset("async_reset_mid_sw");

      run(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
